// File: rtl/apb3_cam_csr_if.sv
// APB3 bus bundle for the camera CSR block: the bridge drives the master side and the CSR slave drives the slave side.
interface apb3_cam_csr_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [31:0]           PWDATA;
    logic                  PREADY;
    logic [31:0]           PRDATA;
    logic                  PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb3_cam_csr.sv
// Camera pipeline CSR slave on APB3. It provides RW control words, RO status words, an ID register,
// self-clearing trigger pulses and a maskable sticky interrupt. Every transfer has exactly one wait state.
module apb3_cam_csr #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned NUM_CTRL   = 8,
    parameter int unsigned NUM_STAT   = 8,
    parameter int unsigned NUM_PULSE  = 4,
    parameter int unsigned NUM_IRQ    = 4,
    parameter logic [31:0] ID_VALUE   = 32'hABCD_5678
) (
    input  logic                    clk,
    input  logic                    reset,
    apb3_cam_csr_if.slave           apb,
    output logic [NUM_CTRL*32-1:0]  ctrl_out,
    input  logic [NUM_STAT*32-1:0]  stat_in,
    output logic [NUM_PULSE-1:0]    pulse_out,
    input  logic [NUM_IRQ-1:0]      irq_event,
    output logic                    irq
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic [31:0]           addr_w;
    logic [5:0]            idx;
    logic hit_ctrl, hit_stat, hit_id, hit_ists, hit_imask, hit_pulse;
    logic legal, commit;
    logic [31:0]           rdata;

    logic                  ack_q, ack_d;
    logic                  pslverr_q, pslverr_d;
    logic [31:0]           prdata_q, prdata_d;
    logic [NUM_PULSE-1:0]  pulse_q, pulse_d;
    logic [NUM_IRQ-1:0]    status_q, status_d;
    logic [NUM_IRQ-1:0]    mask_q, mask_d;
    logic                  irq_q, irq_d;
    logic [31:0]           ctrl_q [NUM_CTRL];
    logic [31:0]           ctrl_d [NUM_CTRL];

    assign paddr  = apb.PADDR;
    assign addr_w = 32'(paddr);
    assign idx    = addr_w[7:2];

    // Address decode over the full address; any unaligned access matches nothing.
    always_comb begin
        hit_ctrl  = 1'b0;
        hit_stat  = 1'b0;
        hit_id    = 1'b0;
        hit_ists  = 1'b0;
        hit_imask = 1'b0;
        hit_pulse = 1'b0;
        if (addr_w[1:0] == 2'b00) begin
            hit_ctrl  = addr_w < 32'(4 * NUM_CTRL);
            hit_stat  = (addr_w >= 32'h100) && (addr_w < 32'h100 + 32'(4 * NUM_STAT));
            hit_id    = addr_w == 32'h200;
            hit_ists  = addr_w == 32'h204;
            hit_imask = addr_w == 32'h208;
            hit_pulse = addr_w == 32'h20C;
        end
        legal = (hit_ctrl | hit_stat | hit_id | hit_ists | hit_imask | hit_pulse)
                && !(apb.PWRITE && (hit_stat || hit_id));
    end

    // Read data mux. Reads of the PULSE register return 0.
    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < NUM_CTRL; i++)
            if (hit_ctrl && idx == 6'(i)) rdata = ctrl_q[i];
        for (int unsigned j = 0; j < NUM_STAT; j++)
            if (hit_stat && idx == 6'(j)) rdata = stat_in[j*32 +: 32];
        if (hit_id)    rdata = ID_VALUE;
        if (hit_ists)  rdata = 32'(status_q);
        if (hit_imask) rdata = 32'(mask_q);
    end

    // Next-state logic. The response is captured on the first access cycle, and the write commits
    // in the PREADY cycle only if the master still holds PSEL/PENABLE.
    always_comb begin
        ack_d     = apb.PSEL & apb.PENABLE & ~ack_q;
        commit    = apb.PSEL & apb.PENABLE & ack_q & apb.PWRITE & legal;
        pslverr_d = ack_d & ~legal;
        prdata_d  = prdata_q;
        if (ack_d && !legal)
            prdata_d = '0;
        else if (ack_d && !apb.PWRITE)
            prdata_d = rdata;
        pulse_d = (commit && hit_pulse) ? apb.PWDATA[NUM_PULSE-1:0] : '0;
        // Clear first, then OR in events, so that a new event wins over a simultaneous clear.
        status_d = status_q;
        if (commit && hit_ists) status_d = status_q & ~apb.PWDATA[NUM_IRQ-1:0];
        status_d = status_d | irq_event;
        mask_d = (commit && hit_imask) ? apb.PWDATA[NUM_IRQ-1:0] : mask_q;
        irq_d  = |(status_q & mask_q);
        for (int unsigned i = 0; i < NUM_CTRL; i++)
            ctrl_d[i] = (commit && hit_ctrl && idx == 6'(i)) ? apb.PWDATA : ctrl_q[i];
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q     <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            pulse_q   <= '0;
            status_q  <= '0;
            mask_q    <= '0;
            irq_q     <= 1'b0;
            for (int unsigned i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= '0;
        end else begin
            ack_q     <= ack_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            pulse_q   <= pulse_d;
            status_q  <= status_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
            for (int unsigned i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= ctrl_d[i];
        end
    end

    // Pack the control words onto the flat output bus.
    always_comb begin
        ctrl_out = '0;
        for (int unsigned i = 0; i < NUM_CTRL; i++) ctrl_out[i*32 +: 32] = ctrl_q[i];
    end

    assign apb.PREADY  = ack_q;
    assign apb.PSLVERR = pslverr_q;
    assign apb.PRDATA  = prdata_q;
    assign pulse_out   = pulse_q;
    assign irq         = irq_q;
endmodule

// File: tb/tb_apb3_cam_csr.sv
// Self-checking bench for apb3_cam_csr. It uses a vector table of APB accesses with a response
// scoreboard, and adds hand-written sequences for pulses, the sticky IRQ and reset mid-transfer.
module tb_apb3_cam_csr;
    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] ctrl_out;
    logic [255:0] stat_in;
    logic [3:0]   pulse_out;
    logic [3:0]   irq_event;
    logic         irq;

    int total = 0;
    int bad   = 0;

    apb3_cam_csr_if #(.ADDR_WIDTH(12)) bus ();

    apb3_cam_csr #(
        .ADDR_WIDTH(12), .NUM_CTRL(8), .NUM_STAT(8), .NUM_PULSE(4), .NUM_IRQ(4),
        .ID_VALUE(32'hABCD_5678)
    ) dut (
        .clk(clk), .reset(reset), .apb(bus.slave), .ctrl_out(ctrl_out), .stat_in(stat_in),
        .pulse_out(pulse_out), .irq_event(irq_event), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk_data;
    } resp_t;

    typedef struct {
        logic [11:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        bit          chk_data;
    } vec_t;

    resp_t sb[$];
    int    p0_cycles = 0;
    int    p0_adjacent = 0;
    logic  p0_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: each PREADY cycle consumes one expected response.
    always @(negedge clk) begin
        if (bus.PREADY === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pready: got 1 expected 0");
            end else begin
                resp_t r;
                r = sb.pop_front();
                chk("pslverr", 32'(bus.PSLVERR), 32'(r.err));
                if (r.chk_data) chk("prdata", bus.PRDATA, r.rdata);
            end
        end
        if (pulse_out[0] === 1'b1) begin
            p0_cycles++;
            if (p0_prev) p0_adjacent++;
        end
        p0_prev = pulse_out[0];
    end

    // One APB transfer, from setup (T) through the PREADY cycle (T+2). The caller then starts the
    // next transfer (back-to-back) or calls idle().
    task automatic xfer(input logic [11:0] a, input logic w, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input bit cd);
        resp_t r;
        @(posedge clk); #1;
        bus.PADDR = a; bus.PWRITE = w; bus.PWDATA = wd; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        r.rdata = er; r.err = ee; r.chk_data = cd;
        sb.push_back(r);
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        chk("pready_t1", 32'(bus.PREADY), 32'd0);
        @(posedge clk); #1;
        chk("pready_t2", 32'(bus.PREADY), 32'd1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        xfer(a, 1'b1, d, 32'd0, 1'b0, 1'b0);
        idle();
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] e);
        xfer(a, 1'b0, 32'd0, e, 1'b0, 1'b1);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        vec_t v;
        int   p0_base;

        for (int j = 0; j < 8; j++) stat_in[j*32 +: 32] = 32'hC0DE_0000 | 32'(j);
        reset = 1'b1;
        irq_event = '0;
        bus.PADDR = '0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PWDATA = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_pready", 32'(bus.PREADY), 32'd0);
        chk("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
        chk("rst_prdata", bus.PRDATA, 32'd0);
        chk("rst_pulse", 32'(pulse_out), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        for (int i = 0; i < 8; i++) chk("rst_ctrl", ctrl_out[i*32 +: 32], 32'd0);

        // addr, write, wdata, exp_rdata, exp_err, check_data
        vecs.push_back('{12'h200, 1'b0, 32'h0,        32'hABCD_5678, 1'b0, 1'b1});
        vecs.push_back('{12'h000, 1'b0, 32'h0,        32'h0,         1'b0, 1'b1});
        vecs.push_back('{12'h004, 1'b1, 32'h3,        32'h0,         1'b0, 1'b0});
        vecs.push_back('{12'h004, 1'b0, 32'h0,        32'h3,         1'b0, 1'b1});
        vecs.push_back('{12'h100, 1'b1, 32'hDEAD,     32'h0,         1'b1, 1'b1});
        vecs.push_back('{12'h100, 1'b0, 32'h0,        32'hC0DE_0000, 1'b0, 1'b1});
        vecs.push_back('{12'h11C, 1'b0, 32'h0,        32'hC0DE_0007, 1'b0, 1'b1});
        vecs.push_back('{12'h120, 1'b0, 32'h0,        32'h0,         1'b1, 1'b1});
        vecs.push_back('{12'h300, 1'b0, 32'h0,        32'h0,         1'b1, 1'b1});
        vecs.push_back('{12'h002, 1'b0, 32'h0,        32'h0,         1'b1, 1'b1});
        vecs.push_back('{12'h200, 1'b1, 32'h1,        32'h0,         1'b1, 1'b1});
        vecs.push_back('{12'h200, 1'b0, 32'h0,        32'hABCD_5678, 1'b0, 1'b1});
        vecs.push_back('{12'h20C, 1'b0, 32'h0,        32'h0,         1'b0, 1'b1});
        vecs.push_back('{12'h01C, 1'b1, 32'h1234_5678, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{12'h01C, 1'b0, 32'h0,        32'h1234_5678, 1'b0, 1'b1});
        vecs.push_back('{12'h020, 1'b1, 32'hFFFF,     32'h0,         1'b1, 1'b1});
        vecs.push_back('{12'h006, 1'b1, 32'hFFFF,     32'h0,         1'b1, 1'b1});
        vecs.push_back('{12'h208, 1'b1, 32'hFFFF_FFF0, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{12'h208, 1'b0, 32'h0,        32'h0,         1'b0, 1'b1});
        vecs.push_back('{12'h208, 1'b1, 32'hFFFF_FFFF, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{12'h208, 1'b0, 32'h0,        32'hF,         1'b0, 1'b1});
        vecs.push_back('{12'h208, 1'b1, 32'h0,        32'h0,         1'b0, 1'b0});
        vecs.push_back('{12'h204, 1'b0, 32'h0,        32'h0,         1'b0, 1'b1});
        vecs.push_back('{12'h004, 1'b0, 32'h0,        32'h3,         1'b0, 1'b1});

        foreach (vecs[k]) begin
            v = vecs[k];
            xfer(v.addr, v.write, v.wdata, v.exp_rdata, v.exp_err, v.chk_data);
            idle();
        end

        for (int i = 0; i < 8; i++)
            chk("ctrl_after_table", ctrl_out[i*32 +: 32],
                (i == 1) ? 32'h3 : (i == 7) ? 32'h1234_5678 : 32'h0);
        chk("irq_after_table", 32'(irq), 32'd0);

        // The control word changes only after the commit edge.
        xfer(12'h008, 1'b1, 32'h5555_AAAA, 32'h0, 1'b0, 1'b0);
        chk("ctrl2_before_commit", ctrl_out[2*32 +: 32], 32'h0);
        idle();
        chk("ctrl2_after_commit", ctrl_out[2*32 +: 32], 32'h5555_AAAA);

        // The pulse fires for exactly one cycle, the cycle after the commit.
        xfer(12'h20C, 1'b1, 32'h5, 32'h0, 1'b0, 1'b0);
        chk("pulse_before", 32'(pulse_out), 32'h0);
        idle();
        chk("pulse_fire", 32'(pulse_out), 32'h5);
        @(posedge clk); #1;
        chk("pulse_clear", 32'(pulse_out), 32'h0);

        // Back-to-back writes of 0x1 must give two separate pulses.
        p0_base = p0_cycles;
        xfer(12'h20C, 1'b1, 32'h1, 32'h0, 1'b0, 1'b0);
        xfer(12'h20C, 1'b1, 32'h1, 32'h0, 1'b0, 1'b0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_pulse_cycles", 32'(p0_cycles - p0_base), 32'd2);
        chk("b2b_pulse_adjacent", 32'(p0_adjacent), 32'd0);

        // Sticky IRQ: one-cycle event, irq two cycles later.
        wr(12'h208, 32'h1);
        @(posedge clk); #1 irq_event = 4'b0001;
        @(posedge clk); #1 irq_event = 4'b0000;
        chk("irq_lat1", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("irq_lat2", 32'(irq), 32'd1);
        repeat (3) @(posedge clk);
        #1 chk("irq_sticky", 32'(irq), 32'd1);
        rd(12'h204, 32'h1);
        xfer(12'h204, 1'b1, 32'h1, 32'h0, 1'b0, 1'b0);
        idle();
        chk("irq_after_clear_edge", 32'(irq), 32'd1);
        @(posedge clk); #1;
        chk("irq_fall", 32'(irq), 32'd0);
        rd(12'h204, 32'h0);

        // A W1C coinciding with a held event must not clear the bit.
        @(posedge clk); #1 irq_event = 4'b0001;
        xfer(12'h204, 1'b1, 32'h1, 32'h0, 1'b0, 1'b0);
        idle();
        @(posedge clk); #1 irq_event = 4'b0000;
        rd(12'h204, 32'h1);
        chk("irq_set_wins", 32'(irq), 32'd1);
        wr(12'h204, 32'h1);
        @(posedge clk); #1;
        chk("irq_cleared_final", 32'(irq), 32'd0);

        // Reset asserted during the first access cycle of a write.
        @(posedge clk); #1;
        bus.PADDR = 12'h000; bus.PWRITE = 1'b1; bus.PWDATA = 32'hFFFF_FFFF;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        chk("rst_mid_pready", 32'(bus.PREADY), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid_pready_late", 32'(bus.PREADY), 32'd0);
        chk("rst_mid_ctrl0", ctrl_out[31:0], 32'h0);
        chk("rst_mid_ctrl1", ctrl_out[63:32], 32'h0);
        wr(12'h000, 32'hA5A5_0F0F);
        @(posedge clk); #1;
        chk("post_rst_ctrl0", ctrl_out[31:0], 32'hA5A5_0F0F);
        rd(12'h000, 32'hA5A5_0F0F);

        repeat (2) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
